// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-back FIFO feeding the register file write port with rs/rt forwarding (CLK/Reset, wb_* enqueue side, drain_en/RegWrite/writeSrc/writeData drain side, rs/rt/fwd* forwarding, count/empty/full status)
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 5
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       wb_valid,
  output logic                       wb_ready,
  input  logic [AW-1:0]              writeSrc_in,
  input  logic                       MemtoReg_in,
  input  logic [31:0]                ALUData,
  input  logic [31:0]                DMData,
  input  logic                       drain_en,
  output logic                       RegWrite,
  output logic [AW-1:0]              writeSrc,
  output logic [31:0]                writeData,
  input  logic [AW-1:0]              rs,
  input  logic [AW-1:0]              rt,
  output logic                       fwdHit1,
  output logic                       fwdHit2,
  output logic [31:0]                fwdData1,
  output logic [31:0]                fwdData2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_enq, w_deq;
  assign count    = r_cnt;
  assign empty    = r_cnt == '0;
  assign full     = r_cnt == CW'(DEPTH);
  assign wb_ready = !full;
  assign w_enq    = wb_valid && wb_ready && writeSrc_in != '0;
  assign w_deq    = drain_en && !empty;
  function automatic logic [32:0] lookup(input logic [AW-1:0] a);
    logic [32:0] res;
    res = (RegWrite && writeSrc == a) ? {1'b1, writeData} : 33'd0;
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < r_cnt && r_addr[r_rp + PW'(i)] == a) res = {1'b1, r_data[r_rp + PW'(i)]};
    return (a == '0) ? 33'd0 : res;
  endfunction
  always_comb begin
    {fwdHit1, fwdData1} = lookup(rs);
    {fwdHit2, fwdData2} = lookup(rt);
  end
  always_ff @(posedge CLK)
    if (w_enq && !Reset) begin
      r_addr[r_wp] <= writeSrc_in;
      r_data[r_wp] <= MemtoReg_in ? DMData : ALUData;
    end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      RegWrite  <= 1'b0;
      writeSrc  <= '0;
      writeData <= '0;
    end else begin
      r_wp     <= w_enq ? r_wp + 1'b1 : r_wp;
      r_rp     <= w_deq ? r_rp + 1'b1 : r_rp;
      r_cnt    <= r_cnt + CW'(w_enq) - CW'(w_deq);
      RegWrite <= w_deq;
      if (w_deq) begin
        writeSrc  <= r_addr[r_rp];
        writeData <= r_data[r_rp];
      end
    end
  end
endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back queue between the multi-cycle CPU datapath and the register file write port. It accepts completed write-backs (destination, ALU result, data-memory result, MemtoReg select), resolves the write data at enqueue time, and buffers up to 4 entries. It drains one entry per cycle into the register file as a one-cycle RegWrite pulse. While writes are pending, it supplies forwarded operand data for rs/rt so that register reads never return stale values.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- AW, 5, register address width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- wb_valid  in  1  write-back request present this cycle
- wb_ready  out  1  queue can accept; equals ~full
- writeSrc_in  in  AW  destination register
- MemtoReg_in  in  1  1 selects DMData, 0 selects ALUData
- ALUData  in  32  ALU result
- DMData  in  32  data-memory result
- drain_en  in  1  permits a dequeue this cycle (0 = register file stalled)
- RegWrite  out  1  registered write strobe to register file
- writeSrc  out  AW  registered write address
- writeData  out  32  registered write data
- rs, rt  in  AW  read addresses being decoded this cycle
- fwdHit1, fwdHit2  out  1  combinational: pending write matches rs / rt
- fwdData1, fwdData2  out  32  combinational forwarded data (0 when no hit)
- count  out  3  entries currently queued (0..DEPTH)
- empty, full  out  1  count==0, count==DEPTH

## Operation
- Enqueue: fires when wb_valid && wb_ready. The stored data is MemtoReg_in ? DMData : ALUData, captured at enqueue; later input changes do not affect it.
- Register $0: a request with writeSrc_in==0 is accepted (the handshake completes) but is not stored; count is unchanged.
- Dequeue: fires when drain_en && !empty. At that edge the head entry is moved into the output stage: RegWrite<=1, writeSrc<=head addr, writeData<=head data.
- When no dequeue fires, RegWrite<=0 at the edge. writeSrc and writeData hold their last values.
- Simultaneous enqueue and dequeue: both occur; count is unchanged.
- Full: wb_ready=0 even if a dequeue fires in the same cycle; there is no full-cycle pass-through.
- Empty: an enqueue lands in storage, never directly in the output stage. Minimum queue latency is 1 cycle.
- Pointers: rd/wr pointers wrap modulo DEPTH. An extra occupancy bit, or count, disambiguates full from empty.
- Forwarding sources, checked youngest first:
  1. queued entries, newest to oldest;
  2. the output stage, if RegWrite==1.
- The first address match wins. rs==0 or rt==0 never hits.
- Same-cycle enqueue is not visible to forwarding until the following cycle.
- Forwarding is purely combinational from current state plus rs/rt.

## Timing
- Reset (synchronous, any state): count=0, empty=1, full=0, wb_ready=1, RegWrite=0, writeSrc=0, writeData=0, pointers=0, all fwdHit=0. Reset overrides a same-edge enqueue or dequeue.
- Pending entries are discarded on reset mid-operation.
- Latency: enqueue at edge N, with the queue empty and drain_en=1 at N+1, gives RegWrite=1 in cycle N+1..N+2. The register file writes at edge N+2.
- Throughput: one write-back per cycle sustained while drain_en=1.
- RegWrite is high for exactly one cycle per dequeue. Back-to-back dequeues keep it high continuously.

## Test plan
- Reset, then enqueue {writeSrc_in=2, MemtoReg_in=0, ALUData=1, DMData=2} with drain_en=1 -> next cycle RegWrite=1, writeSrc=2, writeData=1; the cycle after, RegWrite=0 and count=0.
- drain_en=0; enqueue 5 requests to r1..r5, data 10..50 -> wb_ready=0 after the 4th, full=1, count=4, 5th not accepted. Then drain_en=1 -> writes r1..r4 in order with data 10,20,30,40 on consecutive cycles.
- drain_en=0; enqueue r3=7 then r3=9 (MemtoReg_in=1, DMData=9); rs=3 -> fwdHit1=1, fwdData1=9. With rt=4 -> fwdHit2=0, fwdData2=0.
- Enqueue writeSrc_in=0 with ALUData=0xFFFF -> handshake completes, count stays 0, no RegWrite. rs=0 -> fwdHit1=0.
- Fill 3 entries, then hold wb_valid=1 and drain_en=1 for 8 cycles -> count stays 3, pointers wrap, and the write order matches the enqueue order.
- Fill 2 entries, assert Reset for one cycle with wb_valid=1 -> count=0, RegWrite=0, and neither old entry is ever written.
